inv_bvsge_bvshl_sweep_checker: RTL and testbench
================================================

// Module: inv_bvsge_bvshl_sweep_checker
// PURPOSE
//  Downstream verification stage for the combinational Skolem block that solves (x << s) >=s t.
//  It sweeps every (s,t) pair, drives them into the Skolem block and samples the x it returns.
//  It computes the ground-truth invertibility condition by brute-force search over all x.
//  It counts pass/fail/unsat results and latches the first failing triple.
//  It is used on-chip or in simulation to certify the generated Skolem netlists.
// PARAMETERS
//  W        4          operand width in bits (s, t, x)
//  CNT_W    2*W+1      width of the result counters; holds 2^(2W)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  start         in   1      begin a sweep; sampled in IDLE or DONE only
//  s_out         out  W      shift amount driven to the Skolem block (registered)
//  t_out         out  W      target value driven to the Skolem block (registered)
//  x_in          in   W      Skolem output x = f(s_out, t_out); combinational
//  busy          out  1      sweep in progress
//  done          out  1      sweep complete; held until start or rst
//  pass_cnt      out  CNT_W  pairs where the condition is satisfiable and x_in satisfies it
//  fail_cnt      out  CNT_W  pairs where the condition is satisfiable and x_in does not satisfy it
//  unsat_cnt     out  CNT_W  pairs where no x satisfies the condition (x_in is don't-care)
//  fail_valid    out  1      first_fail_* fields hold a valid triple
//  first_fail_s  out  W      s of the first failing pair
//  first_fail_t  out  W      t of the first failing pair
//  first_fail_x  out  W      x_in of the first failing pair
// BEHAVIOUR
//  - Reset: every output is 0 and the FSM enters IDLE. Reset mid-sweep aborts the sweep and clears all counters.
//  - Predicate P(x,s,t) = ($signed(x << s) >= $signed(t)).
//    Shift is logical in W bits; s >= W yields 0.
//  - Sweep order: s is the outer loop and t the inner loop, both unsigned ascending from 0 to 2^W-1.
//  - FSM states and transitions:
//    IDLE   -start->  DRIVE; clear counters, fail_valid and first_fail_*; s=t=0; busy=1.
//    DRIVE  1 cycle; s_out/t_out are stable.  -> SAMPLE
//    SAMPLE 1 cycle; capture x_in into x_q.  -> SEARCH
//    SEARCH exactly 2^W cycles; candidate c = 0..2^W-1, one per cycle.
//           sat |= P(c,s,t). No early exit, so timing is deterministic.  -> CHECK
//    CHECK  1 cycle:
//           sat=0 -> unsat_cnt++.
//           sat=1 and P(x_q) -> pass_cnt++.
//           sat=1 and !P(x_q) -> fail_cnt++; latch first_fail_* only if fail_valid=0, then set fail_valid.
//           Last pair (s=t=2^W-1) -> DONE, busy=0, done=1. Otherwise advance t (wrap to 0, s++) -> DRIVE.
//    DONE   -start-> restart as from IDLE. Otherwise hold all results.
//  - start while busy is ignored. A start held high across several cycles launches only one sweep.
//  - Per-pair latency is 3+2^W cycles. Total is 2^(2W)*(3+2^W) cycles (4864 for W=4).
//    done rises on the cycle after the final CHECK.
//  - Invariant at done: pass_cnt + fail_cnt + unsat_cnt == 2^(2W).
// STRUCTURE
//  - Package inv_chk_pkg: state enum (IDLE, DRIVE, SAMPLE, SEARCH, CHECK, DONE) and function bvshl_sge(x,s,t).
//  - One sub-module, inv_cond_eval: combinational evaluator of P, parameterised by W.
//    Instantiated twice: one for the search candidate, one for x_q.
// TESTING
//  T1 Connect the correct W=4 Skolem block and pulse start.
//     -> done after 4864 cycles; pass=161, fail=0, unsat=95, fail_valid=0.
//  T2 Stub x_in=0 constant.
//     -> pass=144, fail=17, unsat=95; first_fail s=0, t=1, x=0.
//  T3 Assert rst at cycle 100 of a sweep.
//     -> next cycle all outputs 0, busy=0. A new start then reproduces T1 exactly.
//  T4 Hold start high for 10 cycles, and pulse start again at cycle 2000.
//     -> a single sweep completing at cycle 4864. start asserted in DONE restarts with counters cleared.
//  T5 inv_cond_eval unit checks:
//     (x=0011, s=1, t=0110) -> 1
//     (x=0011, s=2, t=0001) -> 0
//     (x=0111, s=4, t=0000) -> 1
//     (x=0111, s=4, t=0001) -> 0
//  T6 Stub x_in = correct Skolem output, corrupted only at s=2, t=3.
//     -> fail=1, pass=160; first_fail s=2, t=3.

Source files
------------

// File: rtl/inv_bvsge_bvshl_sweep_checker_pkg.sv
// Shared types and the reference predicate for the (x << s) >=s t Skolem sweep checker.
package inv_chk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSample,
    StSearch,
    StCheck,
    StDone
  } state_e;

  // P(x,s,t) = signed(x << s) >= signed(t) in w bits; w must be 1..31.
  // The signed compare is done unsigned after flipping the sign bit.
  function automatic logic bvshl_sge(input int unsigned w, input logic [31:0] x,
                                     input logic [31:0] s, input logic [31:0] t);
    logic [31:0] mask;
    logic [31:0] msb;
    logic [31:0] sh;
    mask = (32'd1 << w) - 32'd1;
    msb  = 32'd1 << (w - 32'd1);
    sh   = (s >= 32'(w)) ? 32'd0 : ((x << s) & mask);
    return ((sh ^ msb) & mask) >= ((t ^ msb) & mask);
  endfunction

endpackage

// File: rtl/inv_bvsge_bvshl_sweep_checker_if.sv
// Stimulus/result bundle between the sweep checker and the Skolem block under test.
interface inv_bvsge_bvshl_sweep_checker_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 2 * W + 1
);
  logic             start;
  logic [W-1:0]     s_out;
  logic [W-1:0]     t_out;
  logic [W-1:0]     x_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] unsat_cnt;
  logic             fail_valid;
  logic [W-1:0]     first_fail_s;
  logic [W-1:0]     first_fail_t;
  logic [W-1:0]     first_fail_x;

  modport master (
    output start, x_in,
    input  s_out, t_out, busy, done, pass_cnt, fail_cnt, unsat_cnt,
           fail_valid, first_fail_s, first_fail_t, first_fail_x
  );

  modport slave (
    input  start, x_in,
    output s_out, t_out, busy, done, pass_cnt, fail_cnt, unsat_cnt,
           fail_valid, first_fail_s, first_fail_t, first_fail_x
  );
endinterface

// File: rtl/inv_bvsge_bvshl_sweep_checker_cond_eval.sv
// Combinational evaluator of P(x,s,t) = signed(x << s) >= signed(t) for W-bit operands.
module inv_cond_eval
  import inv_chk_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] t_i,
  output logic         ok_o
);

  assign ok_o = bvshl_sge(W, 32'(x_i), 32'(s_i), 32'(t_i));

endmodule

// File: rtl/inv_bvsge_bvshl_sweep_checker.sv
// Sweeps every (s,t), samples the Skolem x, brute-forces satisfiability and tallies results.
module inv_bvsge_bvshl_sweep_checker
  import inv_chk_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 2 * W + 1
) (
  input logic                             clk,
  input logic                             rst,
  inv_bvsge_bvshl_sweep_checker_if.slave  bus
);

  state_e           state_q, state_d;
  logic [W-1:0]     s_q, s_d, t_q, t_d, x_q, x_d, c_q, c_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, unsat_q, unsat_d;
  logic             fv_q, fv_d;
  logic [W-1:0]     ffs_q, ffs_d, fft_q, fft_d, ffx_q, ffx_d;
  logic             cand_ok, xq_ok;

  inv_cond_eval #(.W(W)) u_cand_eval (.x_i(c_q), .s_i(s_q), .t_i(t_q), .ok_o(cand_ok));
  inv_cond_eval #(.W(W)) u_xq_eval   (.x_i(x_q), .s_i(s_q), .t_i(t_q), .ok_o(xq_ok));

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    x_d     = x_q;
    c_d     = c_q;
    sat_d   = sat_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unsat_d = unsat_q;
    fv_d    = fv_q;
    ffs_d   = ffs_q;
    fft_d   = fft_q;
    ffx_d   = ffx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StDrive;
          s_d     = '0;
          t_d     = '0;
          pass_d  = '0;
          fail_d  = '0;
          unsat_d = '0;
          fv_d    = 1'b0;
          ffs_d   = '0;
          fft_d   = '0;
          ffx_d   = '0;
        end
      end
      StDrive: state_d = StSample;
      StSample: begin
        x_d     = bus.x_in;
        c_d     = '0;
        sat_d   = 1'b0;
        state_d = StSearch;
      end
      // Full-length search regardless of an early hit keeps per-pair timing fixed.
      StSearch: begin
        sat_d = sat_q | cand_ok;
        c_d   = c_q + 1'b1;
        if (c_q == '1) state_d = StCheck;
      end
      StCheck: begin
        if (!sat_q) begin
          unsat_d = unsat_q + 1'b1;
        end else if (xq_ok) begin
          pass_d = pass_q + 1'b1;
        end else begin
          fail_d = fail_q + 1'b1;
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffs_d = s_q;
            fft_d = t_q;
            ffx_d = x_q;
          end
        end
        if (s_q == '1 && t_q == '1) begin
          state_d = StDone;
        end else begin
          state_d = StDrive;
          t_d     = t_q + 1'b1;
          if (t_q == '1) s_d = s_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      t_q     <= '0;
      x_q     <= '0;
      c_q     <= '0;
      sat_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      unsat_q <= '0;
      fv_q    <= 1'b0;
      ffs_q   <= '0;
      fft_q   <= '0;
      ffx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      x_q     <= x_d;
      c_q     <= c_d;
      sat_q   <= sat_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      unsat_q <= unsat_d;
      fv_q    <= fv_d;
      ffs_q   <= ffs_d;
      fft_q   <= fft_d;
      ffx_q   <= ffx_d;
    end
  end

  assign bus.s_out        = s_q;
  assign bus.t_out        = t_q;
  assign bus.busy         = (state_q == StDrive) || (state_q == StSample) ||
                            (state_q == StSearch) || (state_q == StCheck);
  assign bus.done         = (state_q == StDone);
  assign bus.pass_cnt     = pass_q;
  assign bus.fail_cnt     = fail_q;
  assign bus.unsat_cnt    = unsat_q;
  assign bus.fail_valid   = fv_q;
  assign bus.first_fail_s = ffs_q;
  assign bus.first_fail_t = fft_q;
  assign bus.first_fail_x = ffx_q;

endmodule

// File: tb/tb_inv_bvsge_bvshl_sweep_checker.sv
// Bench for the sweep checker: table-driven Skolem stubs scored against an integer model.
module tb_inv_bvsge_bvshl_sweep_checker;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 2 * W + 1;
  localparam int          NPAIR = 256;
  localparam int          SWEEP = 4864;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_bvsge_bvshl_sweep_checker_if #(.W(W), .CNT_W(CNT_W)) bus ();

  inv_bvsge_bvshl_sweep_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [3:0] ux, us, ut;
  logic       uok;
  inv_cond_eval #(.W(W)) u_eval (.x_i(ux), .s_i(us), .t_i(ut), .ok_o(uok));

  logic [3:0] xtab [NPAIR];
  assign bus.x_in = xtab[{bus.s_out, bus.t_out}];

  int n_checks = 0;
  int n_fail   = 0;
  int e_pass, e_fail, e_unsat, e_fv, e_fs, e_ft, e_fx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Signed compare via plain integer arithmetic on two's-complement values.
  function automatic bit ref_p(int x, int s, int t);
    int sh, sv, tv;
    sh = (s >= 4) ? 0 : ((x << s) % 16);
    sv = (sh >= 8) ? sh - 16 : sh;
    tv = (t >= 8) ? t - 16 : t;
    return sv >= tv;
  endfunction

  function automatic int good_x(int s, int t);
    int g = 0;
    for (int c = 15; c >= 0; c--) if (ref_p(c, s, t)) g = c;
    return g;
  endfunction

  // 0: correct Skolem, 1: constant 0, 2: correct but corrupted at (2,3), 3: random
  task automatic set_mode(input int m);
    for (int i = 0; i < NPAIR; i++) begin
      case (m)
        0:       xtab[i] = 4'(good_x(i / 16, i % 16));
        1:       xtab[i] = 4'd0;
        2:       xtab[i] = (i == 2 * 16 + 3) ? 4'd0 : 4'(good_x(i / 16, i % 16));
        default: xtab[i] = 4'($urandom_range(0, 15));
      endcase
    end
  endtask

  task automatic compute_expected();
    bit sat;
    e_pass = 0; e_fail = 0; e_unsat = 0; e_fv = 0; e_fs = 0; e_ft = 0; e_fx = 0;
    for (int s = 0; s < 16; s++) begin
      for (int t = 0; t < 16; t++) begin
        sat = 0;
        for (int c = 0; c < 16; c++) if (ref_p(c, s, t)) sat = 1;
        if (!sat) e_unsat++;
        else if (ref_p(int'(xtab[s * 16 + t]), s, t)) e_pass++;
        else begin
          e_fail++;
          if (e_fv == 0) begin
            e_fv = 1; e_fs = s; e_ft = t; e_fx = int'(xtab[s * 16 + t]);
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input int hold, input int pulse_at, output int cycles);
    int n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = (hold > 1);
    while (!bus.done && n < SWEEP + 200) begin
      @(posedge clk); #1;
      n++;
      bus.start = ((n + 1) < hold) || ((n + 1) == pulse_at);
    end
    bus.start = 1'b0;
    cycles = n;
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_pass"}, 32'(bus.pass_cnt), 32'(e_pass));
    check_eq({tag, "_fail"}, 32'(bus.fail_cnt), 32'(e_fail));
    check_eq({tag, "_unsat"}, 32'(bus.unsat_cnt), 32'(e_unsat));
    check_eq({tag, "_fv"}, 32'(bus.fail_valid), 32'(e_fv));
    check_eq({tag, "_ffs"}, 32'(bus.first_fail_s), 32'(e_fs));
    check_eq({tag, "_fft"}, 32'(bus.first_fail_t), 32'(e_ft));
    check_eq({tag, "_ffx"}, 32'(bus.first_fail_x), 32'(e_fx));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s"}, 32'(bus.s_out), 32'd0);
    check_eq({tag, "_t"}, 32'(bus.t_out), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_cnts"}, 32'(bus.pass_cnt | bus.fail_cnt | bus.unsat_cnt), 32'd0);
    check_eq({tag, "_ff"}, 32'({bus.fail_valid, bus.first_fail_s, bus.first_fail_t,
                                bus.first_fail_x}), 32'd0);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0;
    set_mode(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Evaluator vectors: (x,s,t) -> expected
    ux = 4'b0011; us = 4'd1; ut = 4'b0110; #1;
    check_eq("eval_a", 32'(uok), 32'd1);
    ux = 4'b0011; us = 4'd2; ut = 4'b0001; #1;
    check_eq("eval_b", 32'(uok), 32'd0);
    ux = 4'b0111; us = 4'd4; ut = 4'b0000; #1;
    check_eq("eval_c", 32'(uok), 32'd1);
    ux = 4'b0111; us = 4'd4; ut = 4'b0001; #1;
    check_eq("eval_d", 32'(uok), 32'd0);
    for (int i = 0; i < 20; i++) begin
      ux = 4'($urandom_range(0, 15)); us = 4'($urandom_range(0, 15));
      ut = 4'($urandom_range(0, 15)); #1;
      check_eq("eval_rand", 32'(uok), 32'(ref_p(int'(ux), int'(us), int'(ut))));
    end

    set_mode(0); compute_expected();
    run_sweep(1, -1, cyc);
    check_eq("t1_cycles", 32'(cyc), 32'(SWEEP));
    check_results("t1");
    check_eq("t1_pass_abs", 32'(bus.pass_cnt), 32'd161);
    check_eq("t1_unsat_abs", 32'(bus.unsat_cnt), 32'd95);

    set_mode(1); compute_expected();
    run_sweep(1, -1, cyc);
    check_results("t2");
    check_eq("t2_fail_abs", 32'(bus.fail_cnt), 32'd17);
    check_eq("t2_ft_abs", 32'(bus.first_fail_t), 32'd1);

    set_mode(2); compute_expected();
    run_sweep(1, -1, cyc);
    check_results("t6");
    check_eq("t6_fail_abs", 32'(bus.fail_cnt), 32'd1);
    check_eq("t6_fs_abs", 32'(bus.first_fail_s), 32'd2);

    for (int r = 0; r < 2; r++) begin
      set_mode(3); compute_expected();
      run_sweep(1, -1, cyc);
      check_eq("rand_cycles", 32'(cyc), 32'(SWEEP));
      check_results("rand");
      check_eq("rand_sum", 32'(bus.pass_cnt + bus.fail_cnt + bus.unsat_cnt), 32'd256);
    end

    // Reset mid-sweep, then a clean rerun
    set_mode(0); compute_expected();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("t3_rst");
    rst = 1'b0;
    run_sweep(1, -1, cyc);
    check_eq("t3_cycles", 32'(cyc), 32'(SWEEP));
    check_results("t3");

    // Long start hold plus a stray pulse while busy
    run_sweep(10, 2000, cyc);
    check_eq("t4_cycles", 32'(cyc), 32'(SWEEP));
    check_results("t4");
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_eq("t4_restart_busy", 32'(bus.busy), 32'd1);
    check_eq("t4_restart_done", 32'(bus.done), 32'd0);
    check_eq("t4_restart_cnt", 32'(bus.pass_cnt | bus.fail_cnt | bus.unsat_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
